lfsr_seq_checker: RTL and testbench
===================================

Name: lfsr_seq_checker

Overview:
- Receive end of the LED-pattern LFSR generator. Accepts the generator's parallel state word, one word per strobe, and self-synchronises to the sequence.
- Once locked, predicts each next word and flags and counts mismatches.
- Sits beside the generator for loopback self-test, or on a captured input bus in the board's bring-up designs.

Parameters:
- WIDTH, 4, LFSR state width in bits.
- TAPS, 4'b1100, feedback mask. next(s) = {s[WIDTH-2:0], ^(s & TAPS)}; the default gives period 15.
- LOCK_CNT, 4, consecutive correct predictions required to declare lock.
- LOSS_CNT, 3, consecutive mismatches while locked that drop lock.
- CNT_W, 16, width of the error counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  in_data is a new sample this cycle (one-cycle strobe, e.g. the generator's tick).
- in_data  in  WIDTH  received LFSR state word.
- clear  in  1  synchronous clear of err_count.
- locked  out  1  checker is in LOCKED state.
- err_pulse  out  1  one-cycle flag for a mismatched sample while locked.
- err_count  out  CNT_W  saturating count of mismatches while locked.

Behaviour:
- Reset (async): state=HUNT, expected=0, good_cnt=0, bad_cnt=0, locked=0, err_pulse=0, err_count=0.
- Samples are acted on only at clk edges where in_valid=1. With in_valid=0, all state holds and err_pulse=0. Gaps of any length are legal.
- HUNT:
  - Valid sample with in_data!=0: expected<=next(in_data), good_cnt<=0, go to VERIFY.
  - in_data==0 (illegal LFSR state): stay in HUNT.
- VERIFY:
  - Valid sample == expected: expected<=next(in_data), good_cnt+1.
  - When that match is the LOCK_CNT-th consecutive match, go to LOCKED and set bad_cnt<=0.
  - Mismatch with in_data!=0: reseed, expected<=next(in_data), good_cnt<=0, stay in VERIFY.
  - Mismatch with in_data==0: go to HUNT.
  - No errors are counted in HUNT or VERIFY.
- LOCKED:
  - Every valid sample advances the prediction free-running: expected<=next(expected). It is never reseeded from in_data, so a single corrupted word causes exactly one error.
  - Match: bad_cnt<=0.
  - Mismatch: err_pulse asserted for exactly the one cycle following the sampling edge; err_count+1 (saturating); bad_cnt+1.
  - When a mismatch is the LOSS_CNT-th consecutive one: go to HUNT, good_cnt<=0. That mismatch is still counted and pulsed.
- locked is registered. It rises the cycle after the sampling edge that completes lock, and falls the cycle after the edge that causes loss. Total lock latency from the first (seed) sample = 1+LOCK_CNT valid samples.
- err_count:
  - Saturates at all-ones and holds; it does not wrap.
  - clear=1 forces 0 at the next edge. If clear coincides with an error increment, clear wins (result 0); err_pulse still fires.
  - err_count is not cleared by loss of lock, only by rst or clear.
- Simultaneous events: rst overrides everything. clear does not affect state, locked, or err_pulse.
- Width: next() is pure combinational on WIDTH bits, and the feedback is the XOR-reduce of the masked state. good_cnt and bad_cnt are sized by clog2 of their thresholds+1 and never overflow, because they reset on reaching threshold.

Reference sequence (default params, from 1111): 1111, 1110, 1100, 1000, 0001, 0010, 0100, 1001, 0011, 0110, 1101, 1010, 0101, 1011, 0111, then repeats at 1111.

Test Plan:
- Lock acquisition: reset, then feed 1111,1110,1100,1000,0001 with in_valid each cycle -> locked=1 the cycle after 0001, err_count=0, err_pulse never high.
- Single error: after lock, continue 0010 then send 0000 in place of 0100, then 1001,0011 -> one err_pulse, err_count=1, locked stays 1, no further errors.
- Loss of lock: after lock, send three consecutive wrong words (0000,0000,0000) -> err_count=3, locked falls after the third. Then feed a valid sequence from 0110 -> relock after 5 samples, and err_count stays 3.
- Illegal/all-zero and reseed: stream of 0000 -> stays HUNT, locked=0, err_count=0. In VERIFY, 1111,1110,0101,1011,0111,1111,1110 -> reseeds at 0101 and locks after the second 1110.
- Valid gaps and clear: lock with in_valid every 3rd cycle -> same result as back-to-back. Assert clear in the same cycle as an error -> err_count=0 and err_pulse=1.
- Saturation and async reset: CNT_W=2, locked, LOSS_CNT raised to 8, inject 5 errors -> err_count holds 3. Assert rst mid-lock, asynchronously between edges -> locked, err_count, and err_pulse go 0 immediately.

Source files
------------

// File: rtl/lfsr_seq_checker.sv
// Receive-side checker for the LED-pattern LFSR generator: hunts for a legal
// state, verifies LOCK_CNT predictions, then counts mismatches while locked.
module lfsr_seq_checker #(
   parameter int unsigned      WIDTH    = 4,
   parameter logic [WIDTH-1:0] TAPS     = 4'b1100,
   parameter int unsigned      LOCK_CNT = 4,
   parameter int unsigned      LOSS_CNT = 3,
   parameter int unsigned      CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   input  logic             clear,
   output logic             locked,
   output logic             err_pulse,
   output logic [CNT_W-1:0] err_count
);

   localparam int unsigned GOOD_W = $clog2(LOCK_CNT + 1);
   localparam int unsigned BAD_W  = $clog2(LOSS_CNT + 1);

   localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(LOCK_CNT - 1);
   localparam logic [BAD_W-1:0]  BAD_LAST  = BAD_W'(LOSS_CNT - 1);

   localparam logic [1:0] S_HUNT   = 2'd0;
   localparam logic [1:0] S_VERIFY = 2'd1;
   localparam logic [1:0] S_LOCKED = 2'd2;

   function automatic logic [WIDTH-1:0] f_next(input logic [WIDTH-1:0] s);
      return {s[WIDTH-2:0], ^(s & TAPS)};
   endfunction

   logic [1:0]        r_state;
   logic [WIDTH-1:0]  r_expected;
   logic [GOOD_W-1:0] r_good_cnt;
   logic [BAD_W-1:0]  r_bad_cnt;
   logic              r_locked;
   logic              r_err_pulse;
   logic [CNT_W-1:0]  r_err_count;

   logic [WIDTH-1:0]  w_next_data;
   logic [WIDTH-1:0]  w_next_exp;
   logic              w_match;
   logic              w_data_zero;

   assign w_next_data = f_next(in_data);
   assign w_next_exp  = f_next(r_expected);
   assign w_match     = (in_data == r_expected);
   assign w_data_zero = (in_data == '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_HUNT;
         r_expected  <= '0;
         r_good_cnt  <= '0;
         r_bad_cnt   <= '0;
         r_locked    <= 1'b0;
         r_err_pulse <= 1'b0;
         r_err_count <= '0;
      end else begin
         r_err_pulse <= 1'b0;
         if (in_valid) begin
            case (r_state)
               S_HUNT: begin
                  if (!w_data_zero) begin
                     r_expected <= w_next_data;
                     r_good_cnt <= '0;
                     r_state    <= S_VERIFY;
                  end
               end
               S_VERIFY: begin
                  if (w_match) begin
                     r_expected <= w_next_data;
                     if (r_good_cnt == GOOD_LAST) begin
                        r_good_cnt <= '0;
                        r_bad_cnt  <= '0;
                        r_state    <= S_LOCKED;
                        r_locked   <= 1'b1;
                     end else begin
                        r_good_cnt <= r_good_cnt + 1'b1;
                     end
                  end else if (!w_data_zero) begin
                     r_expected <= w_next_data;
                     r_good_cnt <= '0;
                  end else begin
                     r_good_cnt <= '0;
                     r_state    <= S_HUNT;
                  end
               end
               S_LOCKED: begin
                  // Free-running prediction: a corrupted word never reseeds.
                  r_expected <= w_next_exp;
                  if (w_match) begin
                     r_bad_cnt <= '0;
                  end else begin
                     r_err_pulse <= 1'b1;
                     if (r_err_count != '1) begin
                        r_err_count <= r_err_count + 1'b1;
                     end
                     if (r_bad_cnt == BAD_LAST) begin
                        r_bad_cnt  <= '0;
                        r_good_cnt <= '0;
                        r_state    <= S_HUNT;
                        r_locked   <= 1'b0;
                     end else begin
                        r_bad_cnt <= r_bad_cnt + 1'b1;
                     end
                  end
               end
               default: begin
                  r_state  <= S_HUNT;
                  r_locked <= 1'b0;
               end
            endcase
         end
         // Clear takes priority over a same-cycle increment.
         if (clear) begin
            r_err_count <= '0;
         end
      end
   end

   assign locked    = r_locked;
   assign err_pulse = r_err_pulse;
   assign err_count = r_err_count;

endmodule

// File: tb/tb_lfsr_seq_checker.sv
// Directed, table-driven bench for lfsr_seq_checker plus hand-written
// sequences for gapped lock, async reset and counter saturation.
module tb_lfsr_seq_checker;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic [3:0]  in_data;
   logic        clear;
   logic        locked;
   logic        err_pulse;
   logic [15:0] err_count;
   logic        s_locked;
   logic        s_err_pulse;
   logic [1:0]  s_err_count;

   int total;
   int bad;

   lfsr_seq_checker #(
      .WIDTH(4), .TAPS(4'b1100), .LOCK_CNT(4), .LOSS_CNT(3), .CNT_W(16)
   ) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
      .clear(clear), .locked(locked), .err_pulse(err_pulse),
      .err_count(err_count)
   );

   lfsr_seq_checker #(
      .WIDTH(4), .TAPS(4'b1100), .LOCK_CNT(4), .LOSS_CNT(8), .CNT_W(2)
   ) u_sat (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
      .clear(clear), .locked(s_locked), .err_pulse(s_err_pulse),
      .err_count(s_err_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      bit          rb;
      logic        v;
      logic [3:0]  d;
      logic        c;
      logic        el;
      logic        ep;
      logic [15:0] ec;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input bit rb, input logic v, input logic [3:0] d,
                      input logic c, input logic el, input logic ep,
                      input logic [15:0] ec);
      vec_t t;
      t.rb = rb; t.v = v; t.d = d; t.c = c; t.el = el; t.ep = ep; t.ec = ec;
      vecs.push_back(t);
   endtask

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic do_reset();
      in_valid = 1'b0; in_data = '0; clear = 1'b0;
      rst = 1'b1;
      @(posedge clk); @(posedge clk); #1;
      chk("rst_locked", {31'd0, locked}, 32'd0);
      chk("rst_pulse", {31'd0, err_pulse}, 32'd0);
      chk("rst_count", {16'd0, err_count}, 32'd0);
      chk("rst_sat_count", {30'd0, s_err_count}, 32'd0);
      rst = 1'b0;
   endtask

   // Drive one cycle of inputs; outputs are sampled 1 time unit after the edge.
   task automatic step(input logic v, input logic [3:0] d, input logic c);
      in_valid = v; in_data = d; clear = c;
      @(posedge clk); #1;
   endtask

   logic [3:0] seq [0:14];

   initial begin
      total = 0; bad = 0;
      rst = 1'b0; in_valid = 1'b0; in_data = '0; clear = 1'b0;
      seq = '{4'hF, 4'hE, 4'hC, 4'h8, 4'h1, 4'h2, 4'h4, 4'h9,
              4'h3, 4'h6, 4'hD, 4'hA, 4'h5, 4'hB, 4'h7};

      // lock, single error, gap, loss, relock, clear-with-error
      add(1,1,4'hF,0, 0,0,0);
      add(0,1,4'hE,0, 0,0,0);
      add(0,1,4'hC,0, 0,0,0);
      add(0,1,4'h8,0, 0,0,0);
      add(0,1,4'h1,0, 1,0,0);
      add(0,1,4'h2,0, 1,0,0);
      add(0,1,4'h0,0, 1,1,1);
      add(0,1,4'h9,0, 1,0,1);
      add(0,1,4'h3,0, 1,0,1);
      add(0,0,4'h0,0, 1,0,1);
      add(0,0,4'hF,0, 1,0,1);
      add(0,1,4'h0,0, 1,1,2);
      add(0,1,4'h0,0, 1,1,3);
      add(0,1,4'h0,0, 0,1,4);
      add(0,1,4'h6,0, 0,0,4);
      add(0,1,4'hD,0, 0,0,4);
      add(0,1,4'hA,0, 0,0,4);
      add(0,1,4'h5,0, 0,0,4);
      add(0,1,4'hB,0, 1,0,4);
      add(0,1,4'h0,1, 1,1,0);
      add(0,1,4'h0,0, 1,1,1);
      add(0,1,4'hE,0, 1,0,1);
      add(0,0,4'h0,1, 1,0,0);
      // all-zero stream stays in hunt, then reseed inside verify
      add(1,1,4'h0,0, 0,0,0);
      add(0,1,4'h0,0, 0,0,0);
      add(0,1,4'h0,0, 0,0,0);
      add(0,1,4'hF,0, 0,0,0);
      add(0,1,4'hE,0, 0,0,0);
      add(0,1,4'h5,0, 0,0,0);
      add(0,1,4'hB,0, 0,0,0);
      add(0,1,4'h7,0, 0,0,0);
      add(0,1,4'hF,0, 0,0,0);
      add(0,1,4'hE,0, 1,0,0);
      // zero word in verify returns to hunt
      add(1,1,4'hF,0, 0,0,0);
      add(0,1,4'h0,0, 0,0,0);
      add(0,1,4'hE,0, 0,0,0);
      add(0,1,4'hC,0, 0,0,0);
      add(0,1,4'h8,0, 0,0,0);
      add(0,1,4'h1,0, 0,0,0);
      add(0,1,4'h2,0, 1,0,0);

      foreach (vecs[i]) begin
         if (vecs[i].rb) do_reset();
         step(vecs[i].v, vecs[i].d, vecs[i].c);
         chk($sformatf("v%0d_locked", i), {31'd0, locked}, {31'd0, vecs[i].el});
         chk($sformatf("v%0d_pulse", i), {31'd0, err_pulse}, {31'd0, vecs[i].ep});
         chk($sformatf("v%0d_count", i), {16'd0, err_count}, {16'd0, vecs[i].ec});
      end

      // lock with in_valid every third cycle
      do_reset();
      for (int i = 0; i < 5; i++) begin
         step(1'b1, seq[i], 1'b0);
         chk($sformatf("gap%0d_locked", i), {31'd0, locked}, (i == 4) ? 32'd1 : 32'd0);
         for (int k = 0; k < 2; k++) begin
            step(1'b0, 4'h0, 1'b0);
            chk($sformatf("gap%0d_idle%0d", i, k), {31'd0, locked}, (i == 4) ? 32'd1 : 32'd0);
            chk($sformatf("gap%0d_pulse%0d", i, k), {31'd0, err_pulse}, 32'd0);
         end
      end
      chk("gap_count", {16'd0, err_count}, 32'd0);

      // saturation on the 2-bit counter instance, which tolerates 8 misses
      for (int i = 0; i < 5; i++) begin
         step(1'b1, 4'h0, 1'b0);
         chk($sformatf("sat%0d_count", i), {30'd0, s_err_count},
             (i >= 2) ? 32'd3 : 32'(i + 1));
         chk($sformatf("sat%0d_locked", i), {31'd0, s_locked}, 32'd1);
         chk($sformatf("sat%0d_pulse", i), {31'd0, s_err_pulse}, 32'd1);
         chk($sformatf("sat%0d_main_locked", i), {31'd0, locked}, (i >= 2) ? 32'd0 : 32'd1);
      end
      chk("sat_main_count", {16'd0, err_count}, 32'd3);

      // async reset between edges while an error pulse is high
      step(1'b1, 4'h0, 1'b0);
      chk("ar_pre_pulse", {31'd0, s_err_pulse}, 32'd1);
      chk("ar_pre_locked", {31'd0, s_locked}, 32'd1);
      in_valid = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk("ar_locked", {31'd0, s_locked}, 32'd0);
      chk("ar_pulse", {31'd0, s_err_pulse}, 32'd0);
      chk("ar_count", {30'd0, s_err_count}, 32'd0);
      chk("ar_main_count", {16'd0, err_count}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
